// File: rtl/replay_pkg.sv
// Shared defaults and state encoding for the link replay controller.
package replay_pkg;

  localparam int unsigned DW_DEF    = 16;
  localparam int unsigned DEPTH_DEF = 8;
  localparam int unsigned CW_DEF    = $clog2(DEPTH_DEF + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RP_RD = 2'd1,
    RP_WR = 2'd2
  } state_e;

endpackage

// File: rtl/replay_ctrl_if.sv
// Source handshake, link output, ack/nak and FIFO control bundle for replay_ctrl.
interface replay_ctrl_if #(
  parameter int unsigned DW    = replay_pkg::DW_DEF,
  parameter int unsigned DEPTH = replay_pkg::DEPTH_DEF
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic          src_valid;
  logic [DW-1:0] src_data;
  logic          src_ready;
  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic          ack;
  logic          nak;
  logic          fifo_en;
  logic          fifo_wr;
  logic          fifo_rd;
  logic [DW-1:0] fifo_din;
  logic [DW-1:0] fifo_dout;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW-1:0] outstanding;
  logic          busy;
  logic          err_ack;

  modport master (
    input  src_valid, src_data, ack, nak, fifo_dout, fifo_empty, fifo_full,
    output src_ready, tx_valid, tx_data, fifo_en, fifo_wr, fifo_rd, fifo_din,
           outstanding, busy, err_ack
  );

  modport slave (
    output src_valid, src_data, ack, nak, fifo_dout, fifo_empty, fifo_full,
    input  src_ready, tx_valid, tx_data, fifo_en, fifo_wr, fifo_rd, fifo_din,
           outstanding, busy, err_ack
  );
endinterface

// File: rtl/replay_ctrl.sv
// Go-back-N replay controller: words sent to the link are kept in an external
// FIFO until acked; a nak rotates every outstanding word through the FIFO
// again, re-sending it in order at two cycles per word.
module replay_ctrl
  import replay_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input logic           clk,
  input logic           rst_n,
  replay_ctrl_if.master bus
);

  localparam int unsigned    CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  state_e        state, state_nx;
  logic [CW-1:0] outstanding_q, outstanding_nx;
  logic [CW-1:0] rp_cnt, rp_cnt_nx;
  logic [CW-1:0] ack_pend, ack_pend_nx;
  logic          can_take;
  logic          has_word;

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      outstanding_q <= '0;
      rp_cnt        <= '0;
      ack_pend      <= '0;
    end else begin
      state         <= state_nx;
      outstanding_q <= outstanding_nx;
      rp_cnt        <= rp_cnt_nx;
      ack_pend      <= ack_pend_nx;
    end
  end

  // Next-state and outputs; everything is forced low while reset is held.
  always_comb begin
    state_nx       = state;
    outstanding_nx = outstanding_q;
    rp_cnt_nx      = rp_cnt;
    ack_pend_nx    = ack_pend;
    can_take       = 1'b0;
    has_word       = (outstanding_q != '0) && !bus.fifo_empty;
    bus.src_ready  = 1'b0;
    bus.tx_valid   = 1'b0;
    bus.tx_data    = '0;
    bus.fifo_en    = 1'b0;
    bus.fifo_wr    = 1'b0;
    bus.fifo_rd    = 1'b0;
    bus.fifo_din   = '0;
    bus.busy       = 1'b0;
    bus.err_ack    = 1'b0;

    if (rst_n) begin
      bus.fifo_en = 1'b1;
      bus.busy    = (state != IDLE);

      unique case (state)
        IDLE: begin
          can_take      = !bus.fifo_full && !bus.ack && (ack_pend == '0);
          bus.src_ready = can_take;
          if (bus.ack) begin
            if (has_word) begin
              bus.fifo_rd    = 1'b1;
              outstanding_nx = outstanding_q - ONE_C;
            end else begin
              bus.err_ack = 1'b1;
            end
          end else if (ack_pend != '0) begin
            // Acks that arrived during a replay are retired one per cycle.
            ack_pend_nx = ack_pend - ONE_C;
            if (has_word) begin
              bus.fifo_rd    = 1'b1;
              outstanding_nx = outstanding_q - ONE_C;
            end else begin
              bus.err_ack = 1'b1;
            end
          end else if (bus.src_valid && can_take) begin
            bus.fifo_wr    = 1'b1;
            bus.fifo_din   = bus.src_data;
            bus.tx_valid   = 1'b1;
            bus.tx_data    = bus.src_data;
            outstanding_nx = outstanding_q + ONE_C;
          end
          // Replay covers everything still held once this cycle's traffic settles.
          if (bus.nak && (outstanding_nx != '0)) begin
            rp_cnt_nx = outstanding_nx;
            state_nx  = RP_RD;
          end
        end
        RP_RD: begin
          bus.fifo_rd = 1'b1;
          state_nx    = RP_WR;
        end
        RP_WR: begin
          bus.fifo_wr  = 1'b1;
          bus.fifo_din = bus.fifo_dout;
          bus.tx_valid = 1'b1;
          bus.tx_data  = bus.fifo_dout;
          rp_cnt_nx    = rp_cnt - ONE_C;
          state_nx     = (rp_cnt > ONE_C) ? RP_RD : IDLE;
        end
        default: state_nx = IDLE;
      endcase

      if ((state != IDLE) && bus.ack && (ack_pend != DEPTH_C)) begin
        ack_pend_nx = ack_pend + ONE_C;
      end
    end
  end

  assign bus.outstanding = outstanding_q;

endmodule

// File: tb/tb_replay_ctrl.sv
// Scoreboard bench for replay_ctrl with a behavioural FIFO and a queue-based
// reference model of the go-back-N replay behaviour.
module tb_replay_ctrl;
  import replay_pkg::*;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 8;

  logic clk;
  logic rst_n;

  replay_ctrl_if #(.DW(DW), .DEPTH(DEPTH)) bus_if ();

  replay_ctrl #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural FIFO with one-cycle read latency, cleared by the same reset.
  logic [DW-1:0] fmem [DEPTH];
  int            fwp, frp, fcnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwp              <= 0;
      frp              <= 0;
      fcnt             <= 0;
      bus_if.fifo_dout <= '0;
    end else if (bus_if.fifo_en) begin
      if (bus_if.fifo_rd && fcnt > 0) begin
        bus_if.fifo_dout <= fmem[frp];
        frp              <= (frp + 1) % DEPTH;
      end
      if (bus_if.fifo_wr && fcnt < DEPTH) begin
        fmem[fwp] <= bus_if.fifo_din;
        fwp       <= (fwp + 1) % DEPTH;
      end
      fcnt <= fcnt + ((bus_if.fifo_wr && fcnt < DEPTH) ? 1 : 0)
                   - ((bus_if.fifo_rd && fcnt > 0) ? 1 : 0);
    end
  end

  assign bus_if.fifo_full  = (fcnt == DEPTH);
  assign bus_if.fifo_empty = (fcnt == 0);

  // Reference model: words held in link order, snapshot being replayed,
  // remaining replay cycles, and acks deferred until the replay ends.
  logic [DW-1:0] oq[$];
  logic [DW-1:0] rq[$];
  logic [DW-1:0] exp_q[$];
  int            rcyc;
  int            pend;
  int            errors;
  int            checks;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_fifo_en"},     32'(bus_if.fifo_en),     32'd0);
    chk({tag, "_src_ready"},   32'(bus_if.src_ready),   32'd0);
    chk({tag, "_tx_valid"},    32'(bus_if.tx_valid),    32'd0);
    chk({tag, "_tx_data"},     32'(bus_if.tx_data),     32'd0);
    chk({tag, "_fifo_din"},    32'(bus_if.fifo_din),    32'd0);
    chk({tag, "_fifo_wr"},     32'(bus_if.fifo_wr),     32'd0);
    chk({tag, "_fifo_rd"},     32'(bus_if.fifo_rd),     32'd0);
    chk({tag, "_busy"},        32'(bus_if.busy),        32'd0);
    chk({tag, "_err_ack"},     32'(bus_if.err_ack),     32'd0);
    chk({tag, "_outstanding"}, 32'(bus_if.outstanding), 32'd0);
  endtask

  // One cycle of stimulus; the model predicts this cycle's response.
  task automatic step(input logic sv, input logic [DW-1:0] d, input logic a, input logic n);
    logic e_ready, e_err, e_busy, e_rd;
    int   e_out;
    @(negedge clk);
    bus_if.src_valid = sv;
    bus_if.src_data  = d;
    bus_if.ack       = a;
    bus_if.nak       = n;
    #1;
    e_out = oq.size();
    e_err = 1'b0;
    e_rd  = 1'b0;
    if (rcyc > 0) begin
      e_busy  = 1'b1;
      e_ready = 1'b0;
      if (rcyc % 2 == 0) e_rd = 1'b1;
      else exp_q.push_back(rq.pop_front());
      if (a && pend < DEPTH) pend++;
      rcyc--;
    end else begin
      e_busy  = 1'b0;
      e_ready = (oq.size() != DEPTH) && !a && (pend == 0);
      if (a || pend > 0) begin
        if (!a) pend--;
        if (oq.size() > 0) begin
          void'(oq.pop_front());
          e_rd = 1'b1;
        end else begin
          e_err = 1'b1;
        end
      end else if (sv && e_ready) begin
        oq.push_back(d);
        exp_q.push_back(d);
      end
      if (n && oq.size() > 0) begin
        rq   = oq;
        rcyc = 2 * oq.size();
      end
    end
    chk("src_ready",   32'(bus_if.src_ready),   32'(e_ready));
    chk("busy",        32'(bus_if.busy),        32'(e_busy));
    chk("outstanding", 32'(bus_if.outstanding), 32'(e_out));
    chk("err_ack",     32'(bus_if.err_ack),     32'(e_err));
    chk("fifo_rd",     32'(bus_if.fifo_rd),     32'(e_rd));
    chk("fifo_en",     32'(bus_if.fifo_en),     32'd1);
  endtask

  // Monitor: every link word must be the next one the model expects.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (bus_if.fifo_rd && bus_if.fifo_wr) begin
          errors++;
          $display("FAIL rd_wr_overlap: both asserted at %0t", $time);
        end
        if (bus_if.tx_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected: got 0x%0h expected no word at %0t", bus_if.tx_data, $time);
          end else begin
            logic [DW-1:0] w;
            w = exp_q.pop_front();
            chk("tx_data",  32'(bus_if.tx_data),  32'(w));
            chk("fifo_din", 32'(bus_if.fifo_din), 32'(w));
            chk("fifo_wr",  32'(bus_if.fifo_wr),  32'd1);
          end
        end
      end
    end
  end

  initial begin
    errors           = 0;
    checks           = 0;
    rcyc             = 0;
    pend             = 0;
    rst_n            = 1'b0;
    bus_if.src_valid = 1'b1;
    bus_if.src_data  = 16'hABCD;
    bus_if.ack       = 1'b1;
    bus_if.nak       = 1'b0;

    // Outputs held low during reset even with live inputs.
    @(negedge clk);
    #1;
    chk_zero("rst");
    bus_if.src_valid = 1'b0;
    bus_if.src_data  = '0;
    bus_if.ack       = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Five back-to-back writes, then two acks.
    for (int i = 0; i < 5; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("out_after_writes", 32'(bus_if.outstanding), 32'd5);
    step(1'b1, 16'h00AA, 1'b1, 1'b0);
    step(1'b1, 16'h00BB, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("out_after_acks", 32'(bus_if.outstanding), 32'd3);

    // Plain replay of 2,3,4.
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 16'h0F0F, 1'b0, (i == 2));
    step(1'b0, '0, 1'b0, 1'b0);
    chk("out_after_replay", 32'(bus_if.outstanding), 32'd3);

    // Replay with an ack arriving mid-way, retired afterwards.
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, '0, (i == 1), 1'b0);
    step(1'b1, 16'h0077, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("out_after_pend", 32'(bus_if.outstanding), 32'd2);

    // Drain, over-ack, then fill past capacity.
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 11; i++) step(1'b1, 16'(16'h1000 + i), 1'b0, 1'b0);
    chk("full_src_ready", 32'(bus_if.src_ready), 32'd0);
    chk("full_out",       32'(bus_if.outstanding), 32'(DEPTH));

    // Reset while the first replayed word is on the link.
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    bus_if.src_valid = 1'b0;
    bus_if.ack       = 1'b0;
    bus_if.nak       = 1'b0;
    #1;
    exp_q.push_back(rq.pop_front());
    chk("rpwr_tx_valid", 32'(bus_if.tx_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    oq.delete();
    rq.delete();
    exp_q.delete();
    rcyc = 0;
    pend = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0);
    chk("post_rst_out", 32'(bus_if.outstanding), 32'd0);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 99) < 55), 16'($urandom),
           ($urandom_range(0, 99) < 18), ($urandom_range(0, 99) < 5));
    end
    for (int i = 0; i < 40; i++) step(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    #3;
    chk("drain_exp_q", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/replay_ctrl.md
REPLAY_CTRL -- requirements
Module: replay_ctrl

Interface
REQ-001 Parameter DW, default 16, data width; SHALL equal the attached FIFO data width.
REQ-002 Parameter DEPTH, default 8, FIFO entries; CW = clog2(DEPTH+1) SHALL size all counts.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 src_valid  in  1 / src_data  in  DW / src_ready  out  1  new-word handshake from the transmitter.
REQ-006 tx_valid  out  1 / tx_data  out  DW  word driven to the link this cycle.
REQ-007 ack  in  1  one-cycle pulse releasing the oldest outstanding word.
REQ-008 nak  in  1  one-cycle pulse requesting replay of all outstanding words.
REQ-009 fifo_en, fifo_wr, fifo_rd  out  1 / fifo_din  out  DW / fifo_dout  in  DW / fifo_empty, fifo_full  in  1  FIFO control port.
REQ-010 outstanding  out  CW  words held / busy  out  1  replay active / err_ack  out  1  one-cycle pulse for ack with nothing outstanding.

Function
REQ-011 States SHALL be IDLE, RP_RD and RP_WR.
REQ-012 fifo_en SHALL be 1 in every cycle after reset release.
REQ-013 IDLE: src_ready = !fifo_full && !ack && (ack_pend == 0); this SHALL be combinational.
REQ-014 IDLE accept (src_valid && src_ready): fifo_wr=1, fifo_din=src_data, tx_valid=1, tx_data=src_data in the same cycle; outstanding increments.
REQ-015 IDLE ack with outstanding>0: fifo_rd=1; the popped data is discarded; outstanding decrements; no write occurs that cycle.
REQ-016 IDLE ack with outstanding==0: no FIFO access; err_ack pulses for 1 cycle.
REQ-017 ack_pend counter: saturates at DEPTH; increments on each ack in RP_RD or RP_WR; in IDLE with no external ack, a nonzero ack_pend SHALL pop one word per cycle, as in REQ-015, and decrement.
REQ-018 nak in IDLE with outstanding>0 after this cycle's ack: latch rp_cnt = that count and go to RP_RD next cycle; otherwise drop the nak.
REQ-019 nak in RP_RD or RP_WR SHALL be ignored; the replay in progress continues.
REQ-020 RP_RD: fifo_rd=1, go to RP_WR.
REQ-021 RP_WR: fifo_wr=1, fifo_din=fifo_dout, tx_valid=1, tx_data=fifo_dout. rp_cnt decrements. Go to RP_RD if rp_cnt was >1, else IDLE.
REQ-022 The FIFO read latency is 1 cycle; replay costs exactly 2 cycles per word and keeps FIFO order.
REQ-023 The controller SHALL never assert fifo_rd and fifo_wr in the same cycle.
REQ-024 outstanding SHALL be unchanged across a replay, and busy = (state != IDLE).
REQ-025 src_ready SHALL be 0 in RP_RD and RP_WR.
REQ-026 tx_valid SHALL be 0 in cycles without a write.

Reset
REQ-027 While rst_n=0: state=IDLE, outstanding=0, rp_cnt=0, ack_pend=0. All outputs SHALL be 0, including fifo_en, src_ready, tx_data and fifo_din.
REQ-028 Reset mid-replay SHALL abort the replay immediately. The system SHALL reset the FIFO in the same interval so that occupancy matches outstanding=0.

Structure
REQ-029 Package replay_pkg SHALL hold DW, DEPTH and CW defaults plus the state enumeration.
REQ-030 There are no sub-modules. The FIFO is instantiated beside replay_ctrl by the parent.

Verification
REQ-031 Write 0x0000..0x0004 on consecutive cycles -> tx_data 0x0000..0x0004 in the same cycles, outstanding=5, no fifo_rd.
REQ-032 outstanding=5, then ack 2 pulses -> two fifo_rd cycles, outstanding=3, src_ready=0 in both ack cycles.
REQ-033 Stored 0x0002,0x0003,0x0004, then nak -> tx 0x0002,0x0003,0x0004 on alternate cycles over 6 cycles; busy=1 for 6 cycles; outstanding stays 3.
REQ-034 ack pulse during replay -> replay completes unchanged; one pop in the first IDLE cycle; outstanding 3->2.
REQ-035 ack with outstanding=0 -> err_ack=1 for 1 cycle, no FIFO access. Fill to DEPTH=8 -> src_ready=0 while fifo_full.
REQ-036 rst_n low during RP_WR -> all outputs 0 asynchronously; after release, state IDLE and outstanding=0.
